// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit: EX/WB bypass to ID plus a per-register load scoreboard.
// Optional macro FWD_ZERO_REG_EN makes r0 a hardwired zero register.
module fwd_hazard_unit #(
  parameter int NUM_DOMAINS = 1,
  parameter int NUM_SRC     = 3,
  parameter int REG_AW      = 3,
  parameter int LOAD_LAT    = 2,
  parameter int STALL_CW    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]     src_addr,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic [NUM_SRC*NUM_DOMAINS*8-1:0] rf_data,
  input  logic                          ex_wr_en,
  input  logic [REG_AW-1:0]             ex_dst,
  input  logic [NUM_DOMAINS*8-1:0]      ex_result,
  input  logic                          wb_wr_en,
  input  logic [REG_AW-1:0]             wb_dst,
  input  logic [NUM_DOMAINS*8-1:0]      wb_data,
  input  logic                          issue_valid,
  input  logic                          issue_is_load,
  input  logic [REG_AW-1:0]             issue_dst,
  input  logic                          flush,
  output logic [NUM_SRC*NUM_DOMAINS*8-1:0] op_data,
  output logic [NUM_SRC*2-1:0]          fwd_sel,
  output logic                          stall_id,
  output logic [STALL_CW-1:0]           stall_count
);

  localparam int DW   = NUM_DOMAINS * 8;
  localparam int NREG = 1 << REG_AW;
  localparam logic [2:0] LAT = 3'(LOAD_LAT);

`ifdef FWD_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [2:0]         cnt [NREG];
  logic [NUM_SRC-1:0] hazard;
  logic               accept;

  always_comb begin : operand_resolve
    logic [REG_AW-1:0] a;
    logic              is_zero;
    hazard  = '0;
    op_data = '0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a       = src_addr[i*REG_AW +: REG_AW];
      is_zero = ZERO_REG && (a == '0);
      hazard[i] = src_used[i] && !is_zero && (cnt[a] >= 3'd2);
      // A pending load owns its register, so the older EX result must not be bypassed.
      if (is_zero) begin
        op_data[i*DW +: DW] = '0;
        fwd_sel[i*2 +: 2]   = 2'd0;
      end else if (ex_wr_en && (ex_dst == a) && (cnt[a] == 3'd0)) begin
        op_data[i*DW +: DW] = ex_result;
        fwd_sel[i*2 +: 2]   = 2'd1;
      end else if (wb_wr_en && (wb_dst == a)) begin
        op_data[i*DW +: DW] = wb_data;
        fwd_sel[i*2 +: 2]   = 2'd2;
      end else begin
        op_data[i*DW +: DW] = rf_data[i*DW +: DW];
        fwd_sel[i*2 +: 2]   = 2'd0;
      end
    end
  end

  assign stall_id = |hazard;
  assign accept   = issue_valid && !stall_id && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= 3'd0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (flush)
          cnt[r] <= 3'd0;
        else if (accept && issue_is_load && (issue_dst == REG_AW'(r)) && !(ZERO_REG && r == 0))
          cnt[r] <= LAT;
        else if (cnt[r] != 3'd0)
          cnt[r] <= cnt[r] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall_id && (stall_count != '1))
      stall_count <= stall_count + STALL_CW'(1);
  end

endmodule
